uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Parametrised UART transmitter with integrated TX FIFO and baud tick generator.
//  Supports 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits.
//  Sits between the register/bus interface (valid/ready push side) and the uart_txd pin.
//  Successor to the fixed 8N1/8N2 transmitter: adds buffering, frame formats and a busy flag.
// PARAMETERS
//  DATA_W      9   max data bits per frame, legal range 5..9; also the width of tx_data
//  FIFO_DEPTH  8   TX FIFO entries, power of 2, >= 2
//  OVS         16  baud ticks per bit (oversample factor), >= 2
// PORTS
//  clk        in   1                       system clock
//  rst        in   1                       asynchronous reset, active-high
//  cfg_div    in   16                      baud tick period = cfg_div+1 clk cycles
//  cfg_txen   in   1                       transmit enable; gates FIFO pop only
//  cfg_dbits  in   4                       data bits per frame (5..DATA_W)
//  cfg_pen    in   1                       parity enable
//  cfg_podd   in   1                       1 = odd parity, 0 = even parity
//  cfg_nstop  in   1                       0 = 1 stop bit, 1 = 2 stop bits
//  tx_valid   in   1                       push request
//  tx_data    in   DATA_W                  push data, LSB transmitted first
//  tx_ready   out  1                       FIFO not full
//  tx_level   out  $clog2(FIFO_DEPTH+1)    FIFO occupancy
//  tx_busy    out  1                       frame in progress (state != IDLE)
//  uart_txd   out  1                       serial output, idle high
// BEHAVIOUR
//  Reset (async, rst=1): FIFO flushed, state IDLE, counters 0.
//   uart_txd=1, tx_busy=0, tx_level=0, tx_ready=1.
//   Reset mid-frame aborts the frame immediately: txd returns high, no completion.
//  FIFO:
//   - Push when tx_valid & tx_ready.
//   - tx_ready = (tx_level != FIFO_DEPTH), combinational from registered level.
//   - No bypass: a word pushed into an empty FIFO is poppable the next cycle.
//   - Push and pop in the same cycle leave tx_level unchanged.
//   - Push while full is ignored; read/write pointers wrap modulo FIFO_DEPTH.
//  Frame start: in IDLE with cfg_txen=1 and tx_level!=0, pop the head entry.
//   - Latch data, cfg_dbits, cfg_pen, cfg_podd and cfg_nstop into the frame registers.
//     Config changes mid-frame have no effect on that frame.
//   - Clear the baud counters; next state is START.
//   - uart_txd goes low on the clk edge following the pop.
//  cfg_dbits clamp: values <5 are treated as 5; values >DATA_W are treated as DATA_W.
//  Baud: tick_cnt counts 0..cfg_div; it emits a tick on wrap, then smp_cnt counts ticks 0..OVS-1.
//   - Each bit lasts OVS*(cfg_div+1) clk cycles; a bit ends on the tick where smp_cnt==OVS-1.
//  FSM (advance only at bit end):
//   - IDLE   -> START: on pop.
//   - START  -> DATA: txd=0 for 1 bit.
//   - DATA   -> PARITY if pen, else STOP: txd = data LSB-first, bit counter 0..dbits-1;
//     leave DATA after bit dbits-1.
//   - PARITY -> STOP: txd = XOR of the dbits data bits, inverted when podd.
//   - STOP   -> IDLE: txd=1 for 1 or 2 bits per nstop.
//  Back-to-back: IDLE lasts >= 1 clk cycle, so consecutive frames are separated by one
//   extra high clk cycle beyond the stop bits.
//  cfg_txen=0 mid-frame: the current frame completes; no further pops occur.
//  Frame length in clk cycles = (1+dbits+pen+1+nstop)*OVS*(cfg_div+1).
//  tx_busy = 1 for states START..STOP.
// TESTING
//  8N1, cfg_div=0, OVS=16, push 0x55:
//   -> txd low 16 clk, then 1,0,1,0,1,0,1,0 at 16 clk each, then high 16 clk;
//      tx_busy high for 160 clk.
//  7E2, cfg_div=2, push 0x41:
//   -> 7 data bits 1,0,0,0,0,0,1; parity bit 0; two stop bits;
//      each bit 48 clk; frame 528 clk.
//  8O1, push 0xFF:
//   -> parity bit 1; push 0x00 -> parity bit 1. Even mode with the same data -> 0, 0.
//  Fill FIFO with cfg_txen=0 (push 9 words, DEPTH=8):
//   -> tx_ready low after the 8th push; 9th word dropped; tx_level=8.
//   Then set txen=1 -> 8 frames sent in order, 1-clk gap between frames, tx_level reaches 0.
//  Simultaneous push and pop at tx_level=3 -> tx_level stays 3. Push into empty FIFO while IDLE
//   -> pop occurs the next cycle, txd low the cycle after.
//  Assert rst during DATA bit 3 -> txd=1, tx_busy=0 and tx_level=0 asynchronously.
//   After release, a new push transmits a clean frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO and a programmable baud tick generator.
// Frames carry 5..DATA_W data bits, optional even/odd parity and 1 or 2 stop bits.
module uart_tx_fifo #(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int OVS        = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [15:0]                     cfg_div,
    input  logic                            cfg_txen,
    input  logic [3:0]                      cfg_dbits,
    input  logic                            cfg_pen,
    input  logic                            cfg_podd,
    input  logic                            cfg_nstop,
    input  logic                            tx_valid,
    input  logic [DATA_W-1:0]               tx_data,
    output logic                            tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] tx_level,
    output logic                            tx_busy,
    output logic                            uart_txd
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(OVS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    logic [3:0]        dbits_c;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] masked;

    logic [DATA_W-1:0] shreg;
    logic [3:0]        f_dbits;
    logic              f_pen;
    logic              f_nstop;
    logic              f_par;
    logic [3:0]        bit_cnt;
    logic              stop_cnt;

    logic [15:0]       tick_cnt;
    logic [SW-1:0]     smp_cnt;
    logic              tick;
    logic              bit_end;

    assign tx_ready = (tx_level != LW'(FIFO_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign pop      = (state == IDLE) && cfg_txen && (tx_level != '0);
    assign tx_busy  = (state != IDLE);
    assign head     = mem[rd_ptr];

    // NOTE: storage array is not reset; the pointers and level alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   tx_level <= tx_level + 1'b1;
                2'b01:   tx_level <= tx_level - 1'b1;
                default: tx_level <= tx_level;
            endcase
        end
    end

    // NOTE: every variable gets a default first so this always_comb never infers a latch.
    always_comb begin
        dbits_c = cfg_dbits;
        if (cfg_dbits < 4'd5) begin
            dbits_c = 4'd5;
        end else if (cfg_dbits > 4'(DATA_W)) begin
            dbits_c = 4'(DATA_W);
        end
    end

    // Unused upper data bits are zeroed so parity only covers transmitted bits.
    always_comb begin
        mask = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < int'(dbits_c)) begin
                mask[i] = 1'b1;
            end
        end
    end

    assign masked  = head & mask;
    assign tick    = (tick_cnt >= cfg_div);
    assign bit_end = tick && (smp_cnt == SW'(OVS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            uart_txd <= 1'b1;
            shreg    <= '0;
            f_dbits  <= 4'd5;
            f_pen    <= 1'b0;
            f_nstop  <= 1'b0;
            f_par    <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tick_cnt <= '0;
            smp_cnt  <= '0;
        end else begin
            if (state == IDLE) begin
                tick_cnt <= '0;
                smp_cnt  <= '0;
            end else if (tick) begin
                tick_cnt <= '0;
                smp_cnt  <= (smp_cnt == SW'(OVS - 1)) ? '0 : smp_cnt + 1'b1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    uart_txd <= 1'b1;
                    if (pop) begin
                        state    <= START;
                        uart_txd <= 1'b0;
                        shreg    <= masked;
                        f_dbits  <= dbits_c;
                        f_pen    <= cfg_pen;
                        f_nstop  <= cfg_nstop;
                        f_par    <= (^masked) ^ cfg_podd;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        uart_txd <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_cnt  <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == f_dbits - 4'd1) begin
                            if (f_pen) begin
                                state    <= PARITY;
                                uart_txd <= f_par;
                            end else begin
                                state    <= STOP;
                                uart_txd <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            uart_txd <= shreg[0];
                            shreg    <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (f_nstop && !stop_cnt) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            uart_txd <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a per-cycle waveform model built
// from frame rules, plus directed frame-length, parity, FIFO and reset checks.
module tb_uart_tx_fifo;

    localparam int DATA_W     = 9;
    localparam int FIFO_DEPTH = 8;
    localparam int OVS        = 16;
    localparam int LW         = $clog2(FIFO_DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       cfg_div = '0;
    logic              cfg_txen = 1'b0;
    logic [3:0]        cfg_dbits = 4'd8;
    logic              cfg_pen = 1'b0;
    logic              cfg_podd = 1'b0;
    logic              cfg_nstop = 1'b0;
    logic              tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_ready;
    logic [LW-1:0]     tx_level;
    logic              tx_busy;
    logic              uart_txd;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    uart_tx_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .OVS(OVS)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_div   (cfg_div),
        .cfg_txen  (cfg_txen),
        .cfg_dbits (cfg_dbits),
        .cfg_pen   (cfg_pen),
        .cfg_podd  (cfg_podd),
        .cfg_nstop (cfg_nstop),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_level  (tx_level),
        .tx_busy   (tx_busy),
        .uart_txd  (uart_txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents plus the expected txd level for every remaining cycle of the frame.
    logic [DATA_W-1:0] m_q[$];
    bit                m_wave[$];
    bit                m_txd  = 1'b1;
    bit                m_busy = 1'b0;

    task automatic build_frame(input logic [DATA_W-1:0] d);
        int db;
        int len;
        bit par;
        bit bits[$];
        db = int'(cfg_dbits);
        if (db < 5) db = 5;
        if (db > DATA_W) db = DATA_W;
        len = OVS * (int'(cfg_div) + 1);
        par = cfg_podd;
        bits.push_back(1'b0);
        for (int i = 0; i < db; i++) begin
            bits.push_back(d[i]);
            par = par ^ d[i];
        end
        if (cfg_pen) bits.push_back(par);
        bits.push_back(1'b1);
        if (cfg_nstop) bits.push_back(1'b1);
        foreach (bits[k]) begin
            repeat (len) m_wave.push_back(bits[k]);
        end
    endtask

    always @(posedge clk or posedge rst) begin : model
        bit rdy;
        if (rst) begin
            m_q.delete();
            m_wave.delete();
            m_txd  = 1'b1;
            m_busy = 1'b0;
        end else begin
            rdy = (m_q.size() < FIFO_DEPTH);
            if (!m_busy && cfg_txen && m_q.size() != 0) begin
                build_frame(m_q.pop_front());
            end
            if (tx_valid && rdy) m_q.push_back(tx_data);
            if (m_wave.size() != 0) begin
                m_txd  = m_wave.pop_front();
                m_busy = 1'b1;
            end else begin
                m_txd  = 1'b1;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("txd", uart_txd, m_txd);
            check("busy", tx_busy, m_busy);
            check("level", tx_level, m_q.size());
            check("ready", tx_ready, m_q.size() != FIFO_DEPTH);
        end
    end

    task automatic set_cfg(input int div, input int dbits, input bit pen, input bit podd, input bit nstop);
        @(negedge clk);
        cfg_div   = 16'(div);
        cfg_dbits = 4'(dbits);
        cfg_pen   = pen;
        cfg_podd  = podd;
        cfg_nstop = nstop;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        bit done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (m_q.size() == 0 && !m_busy) done = 1'b1;
        end
        check("drain", done, 1);
        @(negedge clk);
    endtask

    task automatic send_measure(input logic [DATA_W-1:0] d, input int par_off,
                                output int blen, output logic pbit);
        push_word(d);
        for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
        check("busy_rise", tx_busy, 1);
        blen = 0;
        pbit = 1'bx;
        while (tx_busy && blen < 20000) begin
            if (blen == par_off) pbit = uart_txd;
            blen++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   blen;
        logic pbit;
        logic [DATA_W-1:0] pd[4] = '{9'h1FF, 9'h000, 9'h0FF, 9'h000};
        bit                po[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_txd", uart_txd, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_level", tx_level, 0);
        check("rst_ready", tx_ready, 1);

        set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
        cfg_txen = 1'b1;
        send_measure(9'h055, 0, blen, pbit);
        check("8n1_len", blen, 160);
        wait_idle(100);

        set_cfg(2, 7, 1'b1, 1'b0, 1'b1);
        send_measure(9'h041, 408, blen, pbit);
        check("7e2_len", blen, 528);
        check("7e2_par", pbit, 0);
        wait_idle(100);

        for (int i = 0; i < 4; i++) begin
            set_cfg(0, 8, 1'b1, po[i], 1'b0);
            send_measure(pd[i], 152, blen, pbit);
            check("8x1_par", pbit, po[i]);
            check("8x1_len", blen, 176);
            wait_idle(100);
        end

        set_cfg(0, 8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 9'h03C;
        @(negedge clk);
        tx_valid = 1'b0;
        check("empty_push_level", tx_level, 1);
        check("empty_push_txd", uart_txd, 1);
        @(negedge clk);
        check("pop_txd_low", uart_txd, 0);
        check("pop_level", tx_level, 0);
        wait_idle(300);

        cfg_txen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 7) check("ready_before_full", tx_ready, 1);
            if (i == 8) check("full_ready", tx_ready, 0);
            tx_valid = 1'b1;
            tx_data  = DATA_W'($urandom);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check("full_level", tx_level, 8);
        check("full_ready_hold", tx_ready, 0);
        cfg_txen = 1'b1;
        wait_idle(3000);

        cfg_txen = 1'b0;
        for (int i = 0; i < 3; i++) push_word(DATA_W'($urandom));
        check("level3", tx_level, 3);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 9'h0E7;
        cfg_txen = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("pushpop_level", tx_level, 3);
        check("pushpop_busy", tx_busy, 1);
        wait_idle(2000);

        push_word(9'h052);
        push_word(9'h011);
        push_word(9'h022);
        repeat (67) @(negedge clk);
        check("prerst_busy", tx_busy, 1);
        check("prerst_txd_bit3", uart_txd, 0);
        check("prerst_level", tx_level, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_txd", uart_txd, 1);
        check("async_rst_busy", tx_busy, 0);
        check("async_rst_level", tx_level, 0);
        @(negedge clk);
        rst = 1'b0;
        send_measure(9'h0A5, 0, blen, pbit);
        check("post_rst_len", blen, 160);
        wait_idle(100);

        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            cfg_div = 16'(e);
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                tx_valid = ($urandom_range(0, 7) == 0);
                tx_data  = DATA_W'($urandom);
                if ($urandom_range(0, 63) == 0) begin
                    cfg_dbits = 4'($urandom_range(0, 15));
                    cfg_pen   = 1'($urandom_range(0, 1));
                    cfg_podd  = 1'($urandom_range(0, 1));
                    cfg_nstop = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 99) == 0) cfg_txen = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            tx_valid = 1'b0;
            cfg_txen = 1'b1;
            wait_idle(20000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
